// File: rtl/regfile_scoreboard.sv
// Register file with optional hardwired zero register, optional write-to-read
// bypass and a per-register busy scoreboard for decode-side hazard stalls.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 16,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   read_loc,
  output logic [NREAD*XLEN-1:0] read_data,
  output logic [NREAD-1:0]      read_busy,
  input  logic                  reserve_valid,
  input  logic [AW-1:0]         reserve_loc,
  output logic                  reserve_ready,
  input  logic                  write_valid,
  input  logic [AW-1:0]         write_loc,
  input  logic [XLEN-1:0]       write_data,
  output logic                  write_err,
  output logic [AW:0]           busy_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  logic wr_zero;
  logic rsv_zero;
  logic write_en;
  logic rsv_set;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_zero  = (ZERO_REG != 0) && (write_loc == '0);
  assign rsv_zero = (ZERO_REG != 0) && (reserve_loc == '0);
  assign write_en = write_valid && !wr_zero;

  assign reserve_ready = !reserve_valid || rsv_zero || !busy[reserve_loc] ||
                         (write_valid && (write_loc == reserve_loc));
  assign rsv_set = reserve_valid && reserve_ready && !rsv_zero;

  // A same-register write+reserve leaves the bit set, so the count only moves
  // when the pre-edge bit was clear (+1) or a clear is not overridden (-1).
  assign cnt_inc = rsv_set && !busy[reserve_loc];
  assign cnt_dec = write_en && busy[write_loc] &&
                   !(rsv_set && (reserve_loc == write_loc));

  // Next busy vector: write clears, reservation sets, reservation wins on a tie.
  always_comb begin
    busy_next = busy;
    if (write_en) busy_next[write_loc] = 1'b0;
    if (rsv_set)  busy_next[reserve_loc] = 1'b1;
  end

  // Architectural state, scoreboard, error pulse and busy counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      busy       <= '0;
      write_err  <= 1'b0;
      busy_count <= '0;
    end else begin
      if (write_en) regs[write_loc] <= write_data;
      busy       <= busy_next;
      write_err  <= write_en && !busy[write_loc];
      busy_count <= busy_count + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_read
    logic [AW-1:0]   loc;
    logic [XLEN-1:0] data;
    logic            busy_bit;

    assign loc = read_loc[g*AW +: AW];

    // Per-port read mux: zero register, then bypass, then stored state.
    always_comb begin
      data     = regs[loc];
      busy_bit = busy[loc];
      if ((ZERO_REG != 0) && (loc == '0)) begin
        data     = '0;
        busy_bit = 1'b0;
      end else if ((BYPASS != 0) && write_valid && (write_loc == loc)) begin
        data     = write_data;
        busy_bit = 1'b0;
      end
    end

    assign read_data[g*XLEN +: XLEN] = data;
    assign read_busy[g]              = busy_bit;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters.
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset;
  logic [7:0]  read_loc;
  logic [63:0] read_data;
  logic [1:0]  read_busy;
  logic        reserve_valid;
  logic [3:0]  reserve_loc;
  logic        reserve_ready;
  logic        write_valid;
  logic [3:0]  write_loc;
  logic [31:0] write_data;
  logic        write_err;
  logic [4:0]  busy_count;

  int checks;
  int failures;

  regfile_scoreboard #(
    .XLEN(32), .NREGS(16), .NREAD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clock(clock), .reset(reset),
    .read_loc(read_loc), .read_data(read_data), .read_busy(read_busy),
    .reserve_valid(reserve_valid), .reserve_loc(reserve_loc),
    .reserve_ready(reserve_ready),
    .write_valid(write_valid), .write_loc(write_loc), .write_data(write_data),
    .write_err(write_err), .busy_count(busy_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    read_loc = 8'h00;
    reserve_valid = 1'b0;
    reserve_loc = 4'd0;
    write_valid = 1'b0;
    write_loc = 4'd0;
    write_data = 32'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state: port0 reads x0, port1 reads x5
    read_loc = {4'd5, 4'd0};
    #1;
    check("rst_data0", read_data[31:0], 64'd0);
    check("rst_data1", read_data[63:32], 64'd0);
    check("rst_busy", read_busy, 64'd0);
    check("rst_count", busy_count, 64'd0);
    check("rst_ready", reserve_ready, 64'd1);
    check("rst_err", write_err, 64'd0);

    // Reserve x5
    @(negedge clock);
    reserve_valid = 1'b1; reserve_loc = 4'd5;
    #1 check("rsv5_ready", reserve_ready, 64'd1);
    @(negedge clock);
    reserve_valid = 1'b0;
    #1;
    check("rsv5_busy", read_busy[1], 64'd1);
    check("rsv5_count", busy_count, 64'd1);
    reserve_valid = 1'b1;
    #1 check("rsv5_again_ready", reserve_ready, 64'd0);
    reserve_valid = 1'b0;

    // Write x5 with bypass
    write_valid = 1'b1; write_loc = 4'd5; write_data = 32'hDEADBEEF;
    #1;
    check("byp5_data", read_data[63:32], 64'hDEADBEEF);
    check("byp5_busy", read_busy[1], 64'd0);
    @(negedge clock);
    write_valid = 1'b0;
    #1;
    check("wr5_count", busy_count, 64'd0);
    check("wr5_err", write_err, 64'd0);
    check("wr5_stored", read_data[63:32], 64'hDEADBEEF);
    check("wr5_busy", read_busy[1], 64'd0);

    // Unreserved write x3 -> write_err pulse
    read_loc = {4'd5, 4'd3};
    write_valid = 1'b1; write_loc = 4'd3; write_data = 32'd7;
    @(negedge clock);
    write_valid = 1'b0;
    #1;
    check("wr3_data", read_data[31:0], 64'd7);
    check("wr3_err_pulse", write_err, 64'd1);
    @(negedge clock);
    #1 check("wr3_err_clear", write_err, 64'd0);

    // Busy x4, then same-cycle write+reserve x4
    read_loc = {4'd5, 4'd4};
    reserve_valid = 1'b1; reserve_loc = 4'd4;
    @(negedge clock);
    #1 check("rsv4_count", busy_count, 64'd1);
    write_valid = 1'b1; write_loc = 4'd4; write_data = 32'd9;
    #1 check("wr_rsv4_ready", reserve_ready, 64'd1);
    @(negedge clock);
    write_valid = 1'b0; reserve_valid = 1'b0;
    #1;
    check("wr_rsv4_data", read_data[31:0], 64'd9);
    check("wr_rsv4_busy", read_busy[0], 64'd1);
    check("wr_rsv4_count", busy_count, 64'd1);
    check("wr_rsv4_err", write_err, 64'd0);

    // Retire x4
    write_valid = 1'b1; write_loc = 4'd4; write_data = 32'd1;
    @(negedge clock);
    write_valid = 1'b0;
    #1;
    check("ret4_count", busy_count, 64'd0);
    check("ret4_data", read_data[31:0], 64'd1);

    // Zero register: reserve x0 then write x0
    read_loc = {4'd5, 4'd0};
    reserve_valid = 1'b1; reserve_loc = 4'd0;
    #1 check("z_ready", reserve_ready, 64'd1);
    @(negedge clock);
    reserve_valid = 1'b0;
    #1;
    check("z_busy", read_busy[0], 64'd0);
    check("z_count_rsv", busy_count, 64'd0);
    write_valid = 1'b1; write_loc = 4'd0; write_data = 32'h1234;
    #1 check("z_nobypass", read_data[31:0], 64'd0);
    @(negedge clock);
    write_valid = 1'b0;
    #1;
    check("z_data", read_data[31:0], 64'd0);
    check("z_err", write_err, 64'd0);
    check("z_count", busy_count, 64'd0);

    // Reserve all 15 non-zero registers
    for (int i = 1; i < 16; i++) begin
      reserve_valid = 1'b1; reserve_loc = 4'(i);
      #1 check("all_ready", reserve_ready, 64'd1);
      @(negedge clock);
    end
    reserve_valid = 1'b0;
    read_loc = {4'd15, 4'd3};
    #1;
    check("all_count", busy_count, 64'd15);
    check("all_busy", read_busy, 64'd3);
    check("full_ready", busy_count == 5'd15 ? 64'd0 : 64'd1, 64'd0);

    // Mid-cycle reset with a write in flight
    @(negedge clock);
    read_loc = {4'd5, 4'd3};
    write_valid = 1'b1; write_loc = 4'd7; write_data = 32'h55;
    #2 reset = 1'b1;
    #1;
    check("mrst_count", busy_count, 64'd0);
    check("mrst_busy", read_busy, 64'd0);
    check("mrst_data0", read_data[31:0], 64'd0);
    check("mrst_data1", read_data[63:32], 64'd0);
    check("mrst_err", write_err, 64'd0);
    @(negedge clock);
    write_valid = 1'b0;
    read_loc = {4'd2, 4'd7};
    #1 check("mrst_drop7", read_data[31:0], 64'd0);
    reset = 1'b0;

    // First edge after release behaves normally
    write_valid = 1'b1; write_loc = 4'd2; write_data = 32'h11;
    @(negedge clock);
    write_valid = 1'b0;
    #1;
    check("post_data", read_data[63:32], 64'h11);
    check("post_err", write_err, 64'd1);
    check("post_count", busy_count, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
